// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared encodings for the MEM-stage load/store unit:
//   - WRITE_* store-size codes driven by decode on mem_write
//   - F3_* load funct3 codes
//   - access size type plus helpers that map decode fields to a size and a
//     byte-lane mask
package mem_stage_lsu_pkg;

  localparam logic [1:0] WRITE_IDLE = 2'b00;
  localparam logic [1:0] WRITE_BYTE = 2'b01;
  localparam logic [1:0] WRITE_HALF = 2'b10;
  localparam logic [1:0] WRITE_WORD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Undefined load encodings fall through to a full word access.
  function automatic size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic size_e store_size(input logic [1:0] wr);
    case (wr)
      WRITE_BYTE: return SZ_BYTE;
      WRITE_HALF: return SZ_HALF;
      default:    return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
// Word-oriented data bus between the LSU (master) and memory (slave).
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata : request, master -> slave
//   bus_gnt                                  : request accepted this cycle
//   bus_rvalid/bus_rdata                     : read response, slave -> master
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend
// Selects the byte/halfword lane of a read word and sign- or zero-extends it.
//   word   : raw bus read data
//   offset : byte offset of the access within the word
//   funct3 : load type (undefined codes return the whole word)
//   result : extended load value
module load_extend
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = XLEN'(lane_b);
      F3_LBU:  result = XLEN'($unsigned(lane_b));
      F3_LH:   result = XLEN'(lane_h);
      F3_LHU:  result = XLEN'($unsigned(lane_h));
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// MEM-stage load/store unit: checks alignment, launches one bus access at a
// time, freezes the pipeline while it is outstanding and returns extended
// load data.
//   clk, rst_n               : clock, asynchronous active-low reset
//   mem_read, mem_write      : load request / store size from decode
//   funct3, addr, wdata      : load type, byte address, right-aligned store data
//   stall                    : pipeline freeze while an access is outstanding
//   load_data, load_valid    : registered load result and its one-cycle strobe
//   misalign                 : one-cycle strobe for a rejected misaligned access
//   bus                      : master side of the data bus
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic [1:0]           mem_write,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  output logic                 stall,
  output logic [XLEN-1:0]      load_data,
  output logic                 load_valid,
  output logic                 misalign,
  mem_stage_lsu_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDATA
  } state_e;

  state_e          state, state_nxt;
  logic            is_load, is_store, aligned, launch, reject;
  size_e           size;
  logic [3:0]      be_p0;
  logic [XLEN-1:0] wdata_p0;

  logic            req_p1, we_p1, load_p1;
  logic [3:0]      be_p1;
  logic [XLEN-1:0] addr_p1, wdata_p1;
  logic [1:0]      off_p1;
  logic [2:0]      funct3_p1;
  logic [XLEN-1:0] ext_data;

  // Stage p0: decode the pipeline request (a load wins over a store)
  always_comb begin
    is_load  = mem_read;
    is_store = !mem_read && (mem_write != WRITE_IDLE);
    size     = is_load ? load_size(funct3) : store_size(mem_write);
    case (size)
      SZ_HALF: aligned = ~addr[0];
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    be_p0 = byte_mask(size, addr[1:0]);
    case (size)
      SZ_BYTE: wdata_p0 = {4{wdata[7:0]}};
      SZ_HALF: wdata_p0 = {2{wdata[15:0]}};
      default: wdata_p0 = wdata;
    endcase
    if (!is_store) wdata_p0 = '0;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (aligned) begin
            launch    = 1'b1;
            state_nxt = REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      REQ:     if (bus.bus_gnt) state_nxt = load_p1 ? RDATA : IDLE;
      RDATA:   if (bus.bus_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p1: request held on the bus until granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_p1     <= 1'b0;
      we_p1      <= 1'b0;
      load_p1    <= 1'b0;
      be_p1      <= '0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      off_p1     <= '0;
      funct3_p1  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      misalign   <= reject;
      load_valid <= 1'b0;
      if (launch) begin
        req_p1    <= 1'b1;
        we_p1     <= is_store;
        load_p1   <= is_load;
        be_p1     <= be_p0;
        addr_p1   <= {addr[XLEN-1:2], 2'b00};
        wdata_p1  <= wdata_p0;
        off_p1    <= addr[1:0];
        funct3_p1 <= funct3;
      end
      if (state == REQ && bus.bus_gnt) begin
        req_p1 <= 1'b0;
        we_p1  <= 1'b0;
      end
      // Stage p2: response capture
      if (state == RDATA && bus.bus_rvalid) begin
        load_data  <= ext_data;
        load_valid <= 1'b1;
      end
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (bus.bus_rdata),
    .offset (off_p1),
    .funct3 (funct3_p1),
    .result (ext_data)
  );

  assign stall         = (state != IDLE);
  assign bus.bus_req   = req_p1;
  assign bus.bus_we    = we_p1;
  assign bus.bus_be    = be_p1;
  assign bus.bus_addr  = addr_p1;
  assign bus.bus_wdata = wdata_p1;

endmodule
